// File: rtl/ifetch_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, NOP, reset PC, opcodes.
package ifetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPC_W    = 7;

  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  // RV32I major opcodes, shared with the decoder
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Force a PC onto a word boundary
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & PC_ALIGN_MASK;
  endfunction

  // Sequential successor; wraps modulo 2^32
  function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
    return XLEN'(pc + PC_STEP);
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request, single IR slot, redirect/kill handling.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] IR,
  output logic [31:0] ir_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = align_pc(RESET_PC);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            kill_q, kill_d;
  logic            req_valid_q, req_valid_d;
  logic            ir_valid_q, ir_valid_d;
  logic [XLEN-1:0] redir_pc_c;

  assign redir_pc_c = align_pc(redirect_pc);

  // Next-state and datapath update for the REQ/WAIT/HOLD fetch loop
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    kill_d   = kill_q;

    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          // redirect cancels any same-cycle handshake
          pc_d = redir_pc_c;
        end else if (req_valid_q && imem_req_ready) begin
          req_pc_d = pc_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          kill_d = 1'b0;
          if (redirect_valid) begin
            pc_d    = redir_pc_c;
            state_d = ST_REQ;
          end else if (kill_q) begin
            // pc already holds the redirect target
            state_d = ST_REQ;
          end else begin
            ir_d    = imem_rdata;
            ir_pc_d = req_pc_q;
            pc_d    = seq_pc(req_pc_q);
            state_d = ST_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = redir_pc_c;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc_c;
          state_d = ST_REQ;
        end else if (ir_ready) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_REQ;
      end
    endcase

    req_valid_d = (state_d == ST_REQ);
    ir_valid_d  = (state_d == ST_HOLD);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      pc_q        <= RESET_PC_ALIGNED;
      req_pc_q    <= RESET_PC_ALIGNED;
      ir_q        <= NOP_INSN;
      ir_pc_q     <= RESET_PC_ALIGNED;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      ir_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      ir_valid_q  <= ir_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign ir_valid       = ir_valid_q;
  assign IR             = ir_q;
  assign ir_pc          = ir_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: scoreboard of expected IR/ir_pc pairs.
module tb_ifetch;
  import ifetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] IR;
  logic [31:0] ir_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t cur_exp;
  logic      ir_valid_prev;

  int checks;
  int errors;

  ifetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .IR             (IR),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Drive point: just after the rising edge
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid) return;
      cyc();
    end
    chk("req_timeout", 32'(imem_req_valid), 32'd1);
  endtask

  // Full fetch: optional stall before accept, response next cycle, optional hold before consume
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int stall, input int hold);
    wait_req();
    chk("req_addr", imem_addr, addr);
    for (int i = 0; i < stall; i++) begin
      cyc();
      chk("stall_valid", 32'(imem_req_valid), 32'd1);
      chk("stall_addr", imem_addr, addr);
    end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("wait_no_req", 32'(imem_req_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rdata     = data;
    sb_q.push_back('{insn: data, pc: addr});
    cyc();
    imem_rsp_valid = 1'b0;
    chk("hold_ir_valid", 32'(ir_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_no_req", 32'(imem_req_valid), 32'd0);
      cyc();
    end
    ir_ready = 1'b1;
    cyc();
    ir_ready = 1'b0;
  endtask

  // Monitor on the falling edge: score each new IR and its stability while held
  always @(negedge clk) begin
    if (ir_valid && !ir_valid_prev) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ir", 32'(ir_valid), 32'd0);
      end else begin
        cur_exp = sb_q.pop_front();
        chk("ir_word", IR, cur_exp.insn);
        chk("ir_pc", ir_pc, cur_exp.pc);
      end
    end else if (ir_valid && ir_valid_prev) begin
      chk("ir_stable", IR, cur_exp.insn);
      chk("ir_pc_stable", ir_pc, cur_exp.pc);
      chk("hold_req_low", 32'(imem_req_valid), 32'd0);
    end
    ir_valid_prev = ir_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    ir_valid_prev  = 1'b0;
    cur_exp        = '0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata     = '0;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    cyc();
    cyc();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir", IR, 32'h0000_0013);
    chk("rst_ir_pc", ir_pc, 32'h0000_0000);
    rst_n = 1'b1;

    // Basic fetch, then sequential address
    fetch(32'h0000_0000, 32'h0050_0093, 0, 0);
    wait_req();
    chk("next_addr", imem_addr, 32'h0000_0004);

    // Long hold in HOLD, then sequential fetch
    fetch(32'h0000_0004, 32'h0010_0113, 0, 5);
    fetch(32'h0000_0008, 32'h0020_0193, 0, 0);

    // Redirect during WAIT, late response dropped
    wait_req();
    chk("pre_kill_addr", imem_addr, 32'h0000_000C);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cyc();
    redirect_valid = 1'b0;
    chk("kill_still_wait", 32'(imem_req_valid), 32'd0);
    cyc();
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    cyc();
    imem_rsp_valid = 1'b0;
    chk("kill_req_valid", 32'(imem_req_valid), 32'd1);
    chk("kill_addr", imem_addr, 32'h0000_0100);
    fetch(32'h0000_0100, 32'h0030_0213, 0, 0);

    // Redirect coincident with response
    wait_req();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hBAD0_BAD0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cyc();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    chk("coinc_no_ir", 32'(ir_valid), 32'd0);
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_addr", imem_addr, 32'h0000_0200);
    fetch(32'h0000_0200, 32'h0040_0293, 0, 0);

    // Redirect in REQ with same-cycle ready cancels handshake; low bits cleared
    wait_req();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    cyc();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("redir_req_addr", imem_addr, 32'hFFFF_FFFC);

    // Stalled request at top of memory, then wrap
    fetch(32'hFFFF_FFFC, 32'h0050_0313, 4, 0);
    wait_req();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    fetch(32'h0000_0000, 32'h0060_0393, 0, 0);

    // Redirect in HOLD without consumption
    wait_req();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'h0070_0413;
    sb_q.push_back('{insn: 32'h0070_0413, pc: 32'h0000_0004});
    cyc();
    imem_rsp_valid = 1'b0;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    cyc();
    redirect_valid = 1'b0;
    chk("hold_redir_ir_valid", 32'(ir_valid), 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h0000_0300);
    fetch(32'h0000_0300, 32'h0080_0493, 0, 0);

    // Reset mid-WAIT, stale response after release ignored
    wait_req();
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_ir_valid", 32'(ir_valid), 32'd0);
    chk("midrst_ir", IR, 32'h0000_0013);
    cyc();
    rst_n          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rdata     = 32'hFEED_FACE;
    cyc();
    imem_rsp_valid = 1'b0;
    chk("stale_no_ir", 32'(ir_valid), 32'd0);
    fetch(32'h0000_0000, 32'h0090_0513, 0, 0);

    cyc();
    cyc();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
